sd_output_buf: RTL and testbench
================================

// Module: sd_output_buf
// PURPOSE
//  Single-entry registered output stage for the srdy/drdy handshake library.
//  Upstream control logic presents a word on the ic_* side; the block captures it
//  into an output register and holds it on the p_* side until the consumer accepts.
//  Gives registered p_srdy/p_data for FSM-driven producers, e.g. the gigabit RX MAC
//  uses width 10 = {code[1:0], data[7:0]}.
//  Full-throughput: one word per clock when the consumer is always ready.
// PARAMETERS
//  width   8   bit width of ic_data / p_data
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      asynchronous, active-high reset
//  ic_srdy  in   1      upstream word valid
//  ic_drdy  out  1      stage can accept a word this cycle (combinational)
//  ic_data  in   width  upstream word
//  p_srdy   out  1      registered output valid
//  p_drdy   in   1      consumer accepts p_data this cycle
//  p_data   out  width  registered output word
// BEHAVIOUR
//  - Reset (async assert, sync release): p_srdy=0, p_data=0.
//  - ic_drdy = p_drdy | ~p_srdy.
//    - Depends only on p_srdy and p_drdy, never on ic_srdy.
//    - Producers may sample ic_drdy before deciding to assert ic_srdy, so there is
//      no combinational loop.
//  - Load: when ic_srdy & ic_drdy, p_data <= ic_data at the next clk edge and
//    p_srdy <= 1. Latency is 1 cycle from ic transfer to p_srdy.
//  - Drain: when p_srdy & p_drdy & ~ic_srdy, p_srdy <= 0. p_data is held.
//  - Simultaneous drain and load (p_srdy & p_drdy & ic_srdy): the new word replaces
//    the old one and p_srdy stays 1. No bubble occurs.
//  - Stall: p_srdy & ~p_drdy gives ic_drdy=0. p_data and p_srdy are held stable
//    until accepted, and ic_data is ignored.
//  - Empty: ~p_srdy gives ic_drdy=1 regardless of p_drdy.
//  - ic_srdy while ic_drdy=0 is ignored. No data is captured and no error is flagged.
//  - Reset mid-transfer: the pending word is discarded and p_srdy drops immediately
//    (async).
//  - Purely synchronous datapath. Only clk and reset are used.
//  - No X propagation: p_data updates only on load.
// TESTING
//  1 Reset: assert reset with ic_srdy=1 -> p_srdy=0, p_data=0, ic_drdy=1 while
//    reset is held.
//  2 Single word: ic_srdy=1, ic_data=0x2A5, p_drdy=0 for 1 cycle -> next cycle
//    p_srdy=1, p_data=0x2A5, ic_drdy=0. Hold 5 cycles: value stable. Then p_drdy=1
//    -> ic_drdy=1, and p_srdy=0 on the following edge.
//  3 Streaming: p_drdy=1 constant, ic_srdy=1 with data 0..15 on consecutive cycles
//    -> p_data 0..15 on consecutive cycles, 1-cycle delay, no gaps.
//  4 Backpressure: stream with p_drdy toggling 1,0,0,1 -> no word lost or
//    duplicated; the word is held across stall cycles; ic_drdy=0 exactly when
//    p_srdy=1 & p_drdy=0.
//  5 Combinational ready: stage full, p_drdy raised mid-cycle -> ic_drdy rises in
//    the same cycle, and a word offered that cycle is loaded with no bubble.
//  6 Random: random ic_srdy/p_drdy for 10k cycles vs a scoreboard -> in-order,
//    lossless delivery; p_data stable while p_srdy & ~p_drdy.

Source files
------------

// File: rtl/sd_output_buf_if.sv
// Handshake bundle for sd_output_buf: the upstream ic_* side and the downstream p_* side.
// The slave modport is the buffer; the master modport is the producer/consumer pair around it.
interface sd_output_buf_if #(
  parameter int width = 8
);
  logic             ic_srdy;
  logic             ic_drdy;
  logic [width-1:0] ic_data;
  logic             p_srdy;
  logic             p_drdy;
  logic [width-1:0] p_data;

  modport slave (
    input  ic_srdy,
    input  ic_data,
    output ic_drdy,
    output p_srdy,
    output p_data,
    input  p_drdy
  );

  modport master (
    output ic_srdy,
    output ic_data,
    input  ic_drdy,
    input  p_srdy,
    input  p_data,
    output p_drdy
  );
endinterface

// File: rtl/sd_output_buf.sv
// Single-entry registered output stage for the srdy/drdy handshake library.
// Captures an upstream word and holds it on the p_* side until the consumer accepts it.
module sd_output_buf #(
  parameter int width = 8
) (
  input  logic           clk,
  input  logic           reset,
  sd_output_buf_if.slave bus
);
  logic             r_srdy;
  logic [width-1:0] r_data;
  logic             w_ic_drdy;
  logic             w_load;
  logic             w_srdy_nxt;

  // Ready never looks at ic_srdy, so a producer may sample it before raising ic_srdy.
  assign w_ic_drdy = bus.p_drdy | ~r_srdy;
  assign w_load    = bus.ic_srdy & w_ic_drdy;

  // Next-valid decode: a load beats a drain, so drain+load in one cycle leaves no bubble.
  always_comb begin
    w_srdy_nxt = r_srdy;
    if (w_load) begin
      w_srdy_nxt = 1'b1;
    end else if (bus.p_drdy) begin
      w_srdy_nxt = 1'b0;
    end else begin
      w_srdy_nxt = r_srdy;
    end
  end

  // Output register; the data word only moves on a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_srdy <= 1'b0;
      r_data <= {width{1'b0}};
    end else begin
      r_srdy <= w_srdy_nxt;
      if (w_load) begin
        r_data <= bus.ic_data;
      end
    end
  end

  assign bus.ic_drdy = w_ic_drdy;
  assign bus.p_srdy  = r_srdy;
  assign bus.p_data  = r_data;
endmodule

// File: tb/tb_sd_output_buf.sv
// Self-checking bench for sd_output_buf: directed scenarios plus a queue scoreboard
// fed at ic-side transfers and drained at p-side transfers.
module tb_sd_output_buf;
  localparam int W = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sd_output_buf_if #(.width(W)) bus ();
  sd_output_buf #(.width(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples on the falling edge, between input updates and the active edge.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic [W-1:0] exp_word;
    logic         exp_full;
    logic         exp_drdy;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        exp_full = (sb.size() != 0);
        exp_drdy = !(exp_full && bus.p_drdy == 1'b0);
        if (prev_stall) begin
          chk("stall_srdy", {31'd0, bus.p_srdy}, 32'd1);
          chk("stall_data", {22'd0, bus.p_data}, {22'd0, prev_data});
        end
        chk("srdy_model", {31'd0, bus.p_srdy}, {31'd0, exp_full});
        chk("ic_drdy", {31'd0, bus.ic_drdy}, {31'd0, exp_drdy});
        if (exp_full && bus.p_drdy) begin
          exp_word = sb.pop_front();
          chk("sb_data", {22'd0, bus.p_data}, {22'd0, exp_word});
        end
        if (bus.ic_srdy && exp_drdy) begin
          sb.push_back(bus.ic_data);
        end
        prev_stall = bus.p_srdy && !bus.p_drdy;
        prev_data  = bus.p_data;
      end
    end
  end

  initial begin
    logic         pat[4];
    logic [W-1:0] d;
    logic         acc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // 1: reset held with ic_srdy asserted
    bus.ic_srdy = 1'b1;
    bus.ic_data = 10'h3FF;
    bus.p_drdy  = 1'b0;
    repeat (3) step();
    chk("rst_srdy", {31'd0, bus.p_srdy}, 32'd0);
    chk("rst_data", {22'd0, bus.p_data}, 32'd0);
    chk("rst_drdy", {31'd0, bus.ic_drdy}, 32'd1);
    bus.ic_srdy = 1'b0;
    reset = 1'b0;
    step();

    // 2: single word with a 5-cycle stall
    bus.ic_srdy = 1'b1;
    bus.ic_data = 10'h2A5;
    bus.p_drdy  = 1'b0;
    step();
    bus.ic_srdy = 1'b0;
    bus.ic_data = 10'h000;
    #1;
    chk("single_srdy", {31'd0, bus.p_srdy}, 32'd1);
    chk("single_data", {22'd0, bus.p_data}, 32'h2A5);
    chk("single_drdy", {31'd0, bus.ic_drdy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_data", {22'd0, bus.p_data}, 32'h2A5);
      chk("hold_srdy", {31'd0, bus.p_srdy}, 32'd1);
    end
    bus.p_drdy = 1'b1;
    #1;
    chk("accept_drdy", {31'd0, bus.ic_drdy}, 32'd1);
    step();
    chk("drained_srdy", {31'd0, bus.p_srdy}, 32'd0);
    chk("drained_data", {22'd0, bus.p_data}, 32'h2A5);

    // 3: streaming at full rate
    bus.p_drdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.ic_srdy = 1'b1;
      bus.ic_data = W'(i);
      step();
      chk("stream_srdy", {31'd0, bus.p_srdy}, 32'd1);
      chk("stream_data", {22'd0, bus.p_data}, i);
    end
    bus.ic_srdy = 1'b0;
    step();
    chk("stream_end", {31'd0, bus.p_srdy}, 32'd0);

    // 4: backpressure pattern 1,0,0,1
    d = 10'h100;
    for (int i = 0; i < 24; i++) begin
      bus.p_drdy  = pat[i % 4];
      bus.ic_srdy = 1'b1;
      bus.ic_data = d;
      #1;
      acc = bus.ic_drdy;
      step();
      if (acc) d = d + 10'd1;
    end
    bus.ic_srdy = 1'b0;
    bus.p_drdy  = 1'b1;
    repeat (3) step();
    chk("bp_empty", sb.size(), 32'd0);

    // 5: ready rising mid-cycle while full
    bus.ic_srdy = 1'b1;
    bus.ic_data = 10'h155;
    bus.p_drdy  = 1'b0;
    step();
    bus.ic_srdy = 1'b0;
    #1;
    chk("full_drdy", {31'd0, bus.ic_drdy}, 32'd0);
    #1;
    bus.p_drdy  = 1'b1;
    bus.ic_srdy = 1'b1;
    bus.ic_data = 10'h0AA;
    #1;
    chk("comb_drdy", {31'd0, bus.ic_drdy}, 32'd1);
    step();
    bus.ic_srdy = 1'b0;
    chk("nobubble_srdy", {31'd0, bus.p_srdy}, 32'd1);
    chk("nobubble_data", {22'd0, bus.p_data}, 32'h0AA);
    step();
    chk("drain5_srdy", {31'd0, bus.p_srdy}, 32'd0);

    // reset mid-transfer drops p_srdy without waiting for a clock
    bus.ic_srdy = 1'b1;
    bus.ic_data = 10'h1C3;
    bus.p_drdy  = 1'b0;
    step();
    bus.ic_srdy = 1'b0;
    chk("pre_rst_srdy", {31'd0, bus.p_srdy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_srdy", {31'd0, bus.p_srdy}, 32'd0);
    chk("async_data", {22'd0, bus.p_data}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // 6: random traffic
    d = 10'h000;
    for (int i = 0; i < 10000; i++) begin
      bus.ic_srdy = 1'($urandom_range(0, 1));
      bus.p_drdy  = 1'($urandom_range(0, 3) != 0);
      bus.ic_data = W'($urandom_range(0, 1023));
      step();
    end
    bus.ic_srdy = 1'b0;
    bus.p_drdy  = 1'b1;
    repeat (3) step();
    chk("rand_empty", sb.size(), 32'd0);
    chk("rand_srdy", {31'd0, bus.p_srdy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
